// File: rtl/mte_stream_engine.sv
// MAC-then-encrypt streaming engine: encrypts a message and appends an encrypted MAC tag,
// or decrypts, buffers and authenticates a message before releasing its plaintext.
module mte_stream_engine #(
  parameter int N          = 256,
  parameter int MAX_BLOCKS = 8,
  parameter int ROT        = 13,
  parameter int EOF_DETECT = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] key,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         done,
  output logic         valid_key,
  output logic         overflow
);

  localparam int AW = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, ENC_RUN, ENC_TAG, DEC_COLLECT, DEC_DISCARD, DEC_DRAIN} state_t;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int r);
    return (x << r) | (x >> (N - r));
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int r);
    return (x >> r) | (x << (N - r));
  endfunction

  function automatic logic has_eof(input logic [N-1:0] x);
    logic f;
    f = 1'b0;
    for (int i = 0; i < N / 8; i++) begin
      if (x[8*i +: 8] == 8'h03) f = 1'b1;
    end
    return f;
  endfunction

  state_t         state, state_d;
  logic [N-1:0]   key_q, mac;
  logic [CW-1:0]  cnt, rd_idx;
  logic [N-1:0]   buf_mem [MAX_BLOCKS];

  logic [N-1:0]   k_eff, mac_cur, enc_in, dec_in;
  logic [CW-1:0]  cnt_cur;
  logic           accept, out_free, out_fire, enc_last, enc_beat, dec_beat, dec_full;

  // Both ports use valid/ready: a beat moves on a rising edge where valid && ready are both high;
  // a producer holding valid keeps its data stable until that edge.
  assign out_fire = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The first beat of a message uses the live key and a fresh MAC before they are latched.
  assign k_eff    = (state == IDLE) ? key : key_q;
  assign mac_cur  = (state == IDLE) ? key : mac;
  assign cnt_cur  = (state == IDLE) ? '0 : cnt;
  assign enc_in   = rotl(in_data ^ k_eff, ROT);
  assign dec_in   = rotr(in_data, ROT) ^ k_eff;
  assign enc_last = in_last || ((EOF_DETECT != 0) && has_eof(in_data));
  assign enc_beat = accept && ((state == IDLE && !mode) || state == ENC_RUN);
  assign dec_beat = accept && ((state == IDLE && mode) || state == DEC_COLLECT);
  assign dec_full = (cnt_cur == CW'(MAX_BLOCKS));

  always_comb begin
    in_ready = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE, ENC_RUN:            in_ready = out_free;
        DEC_COLLECT, DEC_DISCARD: in_ready = 1'b1;
        default:                  in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    if (enc_beat) begin
      state_d = enc_last ? ENC_TAG : ENC_RUN;
    end else if (dec_beat) begin
      if (in_last)       state_d = (cnt_cur == '0) ? IDLE : DEC_DRAIN;
      else if (dec_full) state_d = DEC_DISCARD;
      else               state_d = DEC_COLLECT;
    end else begin
      case (state)
        ENC_TAG:     if (out_fire && out_last) state_d = IDLE;
        DEC_DISCARD: if (accept && in_last)    state_d = IDLE;
        DEC_DRAIN:   if (out_fire && out_last) state_d = IDLE;
        default:     state_d = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      key_q     <= '0;
      mac       <= '0;
      cnt       <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      valid_key <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (accept && state == IDLE) begin
        key_q    <= key;
        overflow <= 1'b0;
        cnt      <= '0;
      end
      if (enc_beat) begin
        out_valid <= 1'b1;
        out_data  <= enc_in;
        out_last  <= 1'b0;
        mac       <= rotl(mac_cur ^ in_data, 1);
      end
      if (dec_beat) begin
        if (in_last) begin
          valid_key <= (dec_in == (mac_cur ^ k_eff));
          rd_idx    <= '0;
          if (cnt_cur == '0) done <= 1'b1;
        end else if (dec_full) begin
          overflow <= 1'b1;
        end else begin
          mac <= rotl(mac_cur ^ dec_in, 1);
          cnt <= cnt_cur + CW'(1);
        end
      end
      case (state)
        ENC_TAG: begin
          // ENC(mac ^ Kl) = rotl(mac ^ Kl ^ Kl, ROT): the key cancels out of the tag.
          if (out_fire && out_last) begin
            done <= 1'b1;
          end else if (out_free) begin
            out_valid <= 1'b1;
            out_data  <= rotl(mac, ROT);
            out_last  <= 1'b1;
          end
        end
        DEC_DISCARD: begin
          if (accept && in_last) begin
            valid_key <= 1'b0;
            done      <= 1'b1;
          end
        end
        DEC_DRAIN: begin
          if (out_fire && out_last) begin
            done <= 1'b1;
          end else if (out_free && rd_idx != cnt) begin
            out_valid <= 1'b1;
            out_data  <= valid_key ? buf_mem[rd_idx[AW-1:0]] : '0;
            out_last  <= (rd_idx == cnt - CW'(1));
            rd_idx    <= rd_idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (dec_beat && !in_last && !dec_full) buf_mem[cnt_cur[AW-1:0]] <= dec_in;
  end

endmodule

// File: doc/mte_stream_engine.md
Name: mte_stream_engine

Overview:
- Sequential, handshaked MAC-then-Encrypt engine for multi-block messages of N-bit blocks.
- Encrypt mode: streams ciphertext blocks, then appends one encrypted MAC tag block.
- Decrypt mode: buffers the decrypted plaintext, verifies the trailing tag, then releases the plaintext, or all-zero blocks on tag mismatch.
- Replaces the fixed single-block combinational MAC/encrypt/compare path with a parametrised streaming block.

Parameters:
N, 256, block/key width in bits (multiple of 8, >=16)
MAX_BLOCKS, 8, decrypt buffer depth in data blocks (power of 2)
ROT, 13, cipher rotate amount (0 < ROT < N)
EOF_DETECT, 1, 1 = in encrypt mode, a plaintext block containing byte 8'h03 ends the message

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
key  input  N  cipher/MAC key; sampled on a message's first accepted beat
mode  input  1  0 = encrypt, 1 = decrypt; sampled on a message's first accepted beat
in_valid  input  1  input beat valid
in_ready  output  1  engine accepts beat
in_data  input  N  plaintext (enc) or ciphertext (dec) block
in_last  input  1  final beat of message (dec: the tag beat)
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_data  output  N  ciphertext/tag (enc) or plaintext (dec)
out_last  output  1  final output beat of message
done  output  1  one-cycle pulse at message completion
valid_key  output  1  dec tag match result; updated at done, held until next done
overflow  output  1  sticky for message: dec data blocks exceeded MAX_BLOCKS

Behaviour:
- Transforms, all rotates on N bits:
  - ENC(x) = rotl(x ^ Kl, ROT); DEC(y) = rotr(y, ROT) ^ Kl, where Kl is the latched key.
  - MAC register: initialised to Kl at message start; per plaintext block P, mac <= rotl(mac ^ P, 1).
  - Tag T = mac_final ^ Kl. Transmitted tag = ENC(T).
- Reset: state IDLE; out_valid, out_last, done, valid_key, overflow, counters = 0; out_data = 0. in_ready = 0 while reset_n low. Reset mid-message aborts it with no done pulse.
- Single output register: a beat transfers when valid && ready; out_data/out_last held stable while out_valid && !out_ready.
- States: IDLE, ENC_RUN, ENC_TAG, DEC_COLLECT, DEC_DISCARD, DEC_DRAIN.
- IDLE: in_ready = !out_valid || out_ready. First accepted beat latches key and mode; that beat is processed per the mode and moves to ENC_RUN or DEC_COLLECT.
- ENC_RUN: in_ready = !out_valid || out_ready.
  - Each accepted P loads out_data = ENC(P) the next cycle (1-cycle latency) and updates mac.
  - Beat is last if in_last, or if EOF_DETECT and any byte of P == 8'h03. On last -> ENC_TAG.
- ENC_TAG: in_ready = 0. When the output register frees, load ENC(T) with out_last = 1. On its handshake: done pulses and state -> IDLE. valid_key unchanged.
- DEC_COLLECT: in_ready = 1.
  - Non-last beat C: buf[cnt] <= DEC(C); mac updated with DEC(C); cnt++.
  - Non-last beat with cnt == MAX_BLOCKS: overflow <= 1, state -> DEC_DISCARD.
  - Last beat C: valid_key <= (DEC(C) == mac ^ Kl). If cnt > 0 -> DEC_DRAIN; if cnt == 0, done pulses and state -> IDLE with no output beat.
- DEC_DISCARD: in_ready = 1; beats dropped. On in_last: valid_key <= 0, done pulses, state -> IDLE with no output.
- DEC_DRAIN: in_ready = 0. Emits buf[0..cnt-1] in order, or all-zeros if valid_key == 0. out_last on the final beat. done pulses on the final handshake; state -> IDLE.
- done pulses exactly once per message, in the cycle after the completing handshake. overflow clears at the next message start.
- EOF detection applies only to encrypt plaintext.

Test Plan:
- N=32, ROT=13, key=0, enc, single beat P=32'h00000001, in_last=1 -> out 32'h00002000, then 32'h00004000 with out_last=1; done once.
- N=32, key=32'hFFFFFFFF, enc, P=32'hFFFFFFFF, last -> out 32'h00000000, then tag 32'h00000000 with out_last; MAC chain checked against a model.
- N=32, key=0, dec, beats 32'h00002000 then 32'h00004000 (last) -> valid_key=1, out 32'h00000001 with out_last, done.
- Same as previous but tag 32'h00004001 -> valid_key=0, out 32'h00000000 with out_last.
- Dec, MAX_BLOCKS=8, 9 data beats + tag -> overflow=1, no out_valid, valid_key=0, done once.
- Enc with EOF_DETECT=1, 3 beats, second contains byte 03, in_last never set -> 2 cipher beats + tag; third beat starts a new message.
- Hold out_ready=0 for 5 cycles mid-stream -> out_data stable, in_ready=0. Assert reset_n low mid-DEC_DRAIN -> all outputs 0 immediately, no done.
